div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter bits, default 32, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port async_reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port dividend  input  bits  rs1 value from the register file read mux.
REQ-007 SHALL have port divisor  input  bits  rs2 value from the register file read mux.
REQ-008 SHALL have port rd_in  input  5  destination register tag.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle result-valid pulse, drives the write-back enable.
REQ-011 SHALL have port result  output  bits  quotient or remainder.
REQ-012 SHALL have port rd_out  output  5  tag captured with the accepted start.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; capture op, operands and rd_in on that edge; go to CALC.
REQ-015 SHALL ignore start while in CALC or FIX, with no effect on the operation in flight.
REQ-016 SHALL run restoring division on operand magnitudes, one quotient bit per cycle, for exactly bits cycles in CALC.
REQ-017 SHALL spend one cycle in FIX applying signs: signed quotient negated if operand signs differ; signed remainder takes the dividend's sign.
REQ-018 SHALL enter DONE after FIX, assert done for exactly one cycle, then return to IDLE unless a start is accepted in DONE.
REQ-019 SHALL raise done bits+2 edges after the edge that accepted start (34 for bits=32).
REQ-020 SHALL drive busy=1 in CALC and FIX only; busy=0 in IDLE and DONE.
REQ-021 SHALL hold result and rd_out stable from the DONE cycle until the next accepted start updates them in DONE.
REQ-022 SHALL return on divisor=0: quotient all ones; remainder equals the dividend, for signed and unsigned ops.
REQ-023 SHALL return on DIV/REM overflow (dividend=-2^(bits-1), divisor=-1): quotient equals the dividend; remainder 0.
REQ-024 SHALL treat dividend=0 as normal, giving quotient 0 and remainder 0 at full latency.

Reset
REQ-025 SHALL, while async_reset_n=0, immediately force IDLE, busy=0, done=0, result=0, rd_out=0 and the internal operands to 0.
REQ-026 SHALL abort any operation in flight on reset, with no done pulse for it after release.
REQ-027 SHALL accept start on the first rising edge after async_reset_n returns high.

Configuration
REQ-028 SHALL honour macro DIV_SPECIAL_FAST_EN: when defined, divide-by-zero and overflow skip CALC/FIX and go straight to DONE, with done 1 edge after acceptance.
REQ-029 SHALL, without DIV_SPECIAL_FAST_EN, run those cases at full bits+2 latency with the identical results of REQ-022/023.

Verification
REQ-030 SHALL cover: DIVU 100/7, rd_in=5 -> done at edge 34, result=14, rd_out=5; REMU -> result=2.
REQ-031 SHALL cover: DIV -100/7 -> result=-14 (0xFFFFFFF2); REM -> result=-2 (0xFFFFFFFE).
REQ-032 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; latency 1 with macro, 34 without.
REQ-033 SHALL cover: second start pulsed at edge 10 of an operation -> ignored, only one done, first result unchanged.
REQ-034 SHALL cover: start in DONE cycle with new operands 9/3 DIVU -> first result seen for one cycle, next done 34 edges later with result=3.
REQ-035 SHALL cover: async_reset_n low at edge 20 of an operation -> busy, done, result and rd_out go to 0 at once; no done follows release.

Source files
------------

// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
// Module      : div_if
// Description : Request/response bundle of the iterative divider. The master
//               side (issue logic or testbench) drives the request; the slave
//               side (div_unit) returns busy/done/result/rd_out.
//               Signals: start, op[1:0], dividend, divisor, rd_in[4:0]
//                        busy, done, result, rd_out[4:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface div_if #(
    parameter int bits = 32
);
    logic            start;
    logic [1:0]      op;
    logic [bits-1:0] dividend;
    logic [bits-1:0] divisor;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [bits-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, op, dividend, divisor, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, op, dividend, divisor, rd_in,
        output busy, done, result, rd_out
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
//               op: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
//               IDLE -> CALC -> FIX -> DONE; done is a one-cycle pulse that
//               rises bits+2 edges after the accepting edge.
//               Ports: clk, async_reset_n (async, active-low),
//                      bus (div_if.slave): start/op/dividend/divisor/rd_in in,
//                      busy/done/result/rd_out out.
//               Optional macro DIV_SPECIAL_FAST_EN: divide-by-zero and signed
//               overflow bypass CALC/FIX and finish one edge after accept.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int bits = 32
) (
    input  wire logic clk,
    input  wire logic async_reset_n,
    div_if.slave      bus
);

    localparam int CW = $clog2(bits + 1);
    localparam logic [CW-1:0] c_last_cnt = CW'(bits);
    localparam logic [bits-1:0] c_int_min = {1'b1, {(bits-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      op_q;
    logic [bits-1:0] a_q;
    logic [bits-1:0] b_q;
    logic [4:0]      rd_q;
    logic [bits-1:0] quo_q;
    logic [bits-1:0] rem_q;
    logic [bits-1:0] dvs_q;
    logic            busy_q;
    logic            done_q;
    logic [bits-1:0] result_q;
    logic [4:0]      rd_out_q;

    logic            w_accept;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [bits-1:0] w_a_mag;
    logic [bits-1:0] w_b_mag;
    logic [bits:0]   w_shifted;
    logic [bits:0]   w_diff;
    logic [bits-1:0] rem_d;
    logic [bits-1:0] quo_d;
    logic [bits-1:0] w_fix_result;
    logic            w_special;
    logic [bits-1:0] w_special_result;

    assign w_accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

    // Signs only matter for DIV/REM (op[0] == 0).
    assign w_a_neg = ~op_q[0] & a_q[bits-1];
    assign w_b_neg = ~op_q[0] & b_q[bits-1];
    assign w_a_mag = w_a_neg ? -a_q : a_q;
    assign w_b_mag = w_b_neg ? -b_q : b_q;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not borrow.
    always_comb begin
        w_shifted = {rem_q, quo_q[bits-1]};
        w_diff    = w_shifted - {1'b0, dvs_q};
        rem_d     = w_diff[bits] ? w_shifted[bits-1:0] : w_diff[bits-1:0];
        quo_d     = {quo_q[bits-2:0], ~w_diff[bits]};
    end

    // Divide-by-zero is forced explicitly because the raw iteration would
    // get its quotient sign-corrected. Signed overflow falls out naturally:
    // magnitude 2^(bits-1) negated is itself and the remainder is zero.
    always_comb begin
        if (b_q == '0) begin
            w_fix_result = op_q[1] ? a_q : '1;
        end else if (op_q[1]) begin
            w_fix_result = w_a_neg ? -rem_q : rem_q;
        end else begin
            w_fix_result = (w_a_neg ^ w_b_neg) ? -quo_q : quo_q;
        end
    end

`ifdef DIV_SPECIAL_FAST_EN
    always_comb begin
        w_special = (bus.divisor == '0) ||
                    (~bus.op[0] && (bus.dividend == c_int_min) && (bus.divisor == '1));
        if (bus.divisor == '0) begin
            w_special_result = bus.op[1] ? bus.dividend : '1;
        end else begin
            w_special_result = bus.op[1] ? '0 : bus.dividend;
        end
    end
`else
    assign w_special        = 1'b0;
    assign w_special_result = c_int_min & '0;
`endif

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (w_accept) begin
                        op_q  <= bus.op;
                        a_q   <= bus.dividend;
                        b_q   <= bus.divisor;
                        rd_q  <= bus.rd_in;
                        cnt_q <= '0;
                        if (w_special) begin
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= w_special_result;
                            rd_out_q <= bus.rd_in;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                CALC: begin
                    // Count 0 loads the magnitudes; counts 1..bits each
                    // retire one quotient bit, MSB first.
                    if (cnt_q == '0) begin
                        quo_q <= w_a_mag;
                        rem_q <= '0;
                        dvs_q <= w_b_mag;
                    end else begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == c_last_cnt) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q  <= DONE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    result_q <= w_fix_result;
                    rd_out_q <= rd_q;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit: directed cases followed by
//               randomized operations compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;
    localparam int BITS     = 32;
    localparam int FULL_LAT = BITS + 2;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic async_reset_n = 1'b1;
    always #5 clk = ~clk;

    div_if #(.bits(BITS)) bus ();
    div_unit #(.bits(BITS)) dut (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .bus           (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain language-level division with the ISA special cases.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == INT_MIN && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
            sa = int'(a);
            sb = int'(b);
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        bit special;
        special = (b == 0) || (!op[0] && a == INT_MIN && b == 32'hFFFF_FFFF);
`ifdef DIV_SPECIAL_FAST_EN
        return special ? 1 : FULL_LAT;
`else
        return special ? FULL_LAT : FULL_LAT;
`endif
    endfunction

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        bus.rd_in    = rd;
        bus.start    = 1'b1;
    endtask

    // Called #1 after the accepting edge; counts edges until done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input bit release_rst);
        int lat, exp_lat;
        exp_lat = ref_lat(op, a, b);
        @(negedge clk);
        if (release_rst) async_reset_n = 1'b1;
        drive(op, a, b, rd);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, " busy"}, 64'(bus.busy), 64'(exp_lat != 1));
        wait_done(lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(bus.result), 64'(ref_div(op, a, b)));
        check({tag, " rd_out"}, 64'(bus.rd_out), 64'(rd));
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int lat, ndone, first_edge;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic [31:0] held;

        bus.start = 1'b0; bus.op = '0; bus.dividend = '0; bus.divisor = '0; bus.rd_in = '0;
        #2 async_reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   64'(bus.busy),   64'd0);
        check("reset done",   64'(bus.done),   64'd0);
        check("reset result", 64'(bus.result), 64'd0);
        check("reset rd_out", 64'(bus.rd_out), 64'd0);

        // First op released together with reset: must be accepted at once.
        run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 5'd5, 1'b1);
        run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 5'd6, 1'b0);
        run_op("div -100/7", 2'b00, -32'sd100, 32'd7, 5'd7, 1'b0);
        run_op("rem -100/7", 2'b10, -32'sd100, 32'd7, 5'd8, 1'b0);
        run_op("div 100/-7", 2'b00, 32'd100, -32'sd7, 5'd9, 1'b0);
        run_op("div ovf",    2'b00, INT_MIN, 32'hFFFF_FFFF, 5'd10, 1'b0);
        run_op("rem ovf",    2'b10, INT_MIN, 32'hFFFF_FFFF, 5'd11, 1'b0);
        run_op("divu 5/0",   2'b01, 32'd5, 32'd0, 5'd12, 1'b0);
        run_op("remu 5/0",   2'b11, 32'd5, 32'd0, 5'd13, 1'b0);
        run_op("div -5/0",   2'b00, -32'sd5, 32'd0, 5'd14, 1'b0);
        run_op("rem -5/0",   2'b10, -32'sd5, 32'd0, 5'd15, 1'b0);
        run_op("div 0/9",    2'b00, 32'd0, 32'd9, 5'd16, 1'b0);
        run_op("remu 0/9",   2'b11, 32'd0, 32'd9, 5'd17, 1'b0);
        run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd18, 1'b0);

        // Second start during CALC must be ignored.
        @(negedge clk);
        drive(2'b01, 32'd1000, 32'd10, 5'd3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        first_edge = 0;
        for (int e = 1; e <= 60; e++) begin
            if (e == 10) drive(2'b01, 32'd77, 32'd1, 5'd30);
            @(posedge clk);
            #1;
            if (e == 10) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                ndone++;
                if (first_edge == 0) first_edge = e;
                held = bus.result;
            end
        end
        check("ignore start done count", 64'(ndone), 64'd1);
        check("ignore start latency", 64'(first_edge), 64'(FULL_LAT));
        check("ignore start result", 64'(held), 64'd100);
        check("ignore start result hold", 64'(bus.result), 64'd100);
        check("ignore start rd_out", 64'(bus.rd_out), 64'd3);

        // Back-to-back: new start issued in the DONE cycle.
        @(negedge clk);
        drive(2'b01, 32'd50, 32'd7, 5'd21);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        check("b2b first result", 64'(bus.result), 64'd7);
        drive(2'b01, 32'd9, 32'd3, 5'd22);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b done drops", 64'(bus.done), 64'd0);
        check("b2b busy", 64'(bus.busy), 64'd1);
        wait_done(lat);
        check("b2b latency", 64'(lat), 64'(FULL_LAT));
        check("b2b result", 64'(bus.result), 64'd3);
        check("b2b rd_out", 64'(bus.rd_out), 64'd22);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        drive(2'b01, 32'd12345, 32'd11, 5'd19);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        async_reset_n = 1'b0;
        #1;
        check("abort busy",   64'(bus.busy),   64'd0);
        check("abort done",   64'(bus.done),   64'd0);
        check("abort result", 64'(bus.result), 64'd0);
        check("abort rd_out", 64'(bus.rd_out), 64'd0);
        @(negedge clk);
        async_reset_n = 1'b1;
        ndone = 0;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("abort no done", 64'(ndone), 64'd0);

        // Randomized operations, biased towards the special cases.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = INT_MIN; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            rd = 5'($urandom_range(0, 31));
            run_op($sformatf("rand%0d op%0d", i, op), op, a, b, rd, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
